// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle multiply sequencer:
// default operand width, FSM state encodings and shared-adder operand selects.
package mul_seq_ctrl_pkg;

  localparam int unsigned MUL_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABS_A  = 3'd1,
    ST_ABS_B  = 3'd2,
    ST_MUL    = 3'd3,
    ST_NEG_LO = 3'd4,
    ST_NEG_HI = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Operand/carry-in selection for the single shared adder.
  typedef enum logic [1:0] {
    SEL_INV_MCAND = 2'd0,  // ~mcand + 0 + 1
    SEL_INV_LO    = 2'd1,  // ~lo    + 0 + 1
    SEL_INV_HI    = 2'd2,  // ~hi    + 0 + cy
    SEL_ACC       = 2'd3   //  hi    + mcand + 0
  } add_sel_t;

endpackage

// File: rtl/mul_seq_ctrl_add32.sv
// add32: WIDTH-bit ripple-carry adder built from full-adder cells.
// Ports: a, b (addends), cin (carry in), sum (result), cout (carry out).
module add32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle signed/unsigned WIDTH x WIDTH multiplier that
// time-shares one ripple adder for operand negation, shift-add and product
// negation. Fixed 37-cycle accept-to-result latency.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start_valid/ready     request handshake (ready only in IDLE)
//   sgn, A, B             signedness and operands, sampled at accept
//   res_valid/ready       result handshake; P held until res_ready
//   P                     2*WIDTH-bit product, kept until next completion
//   busy                  high in every state except IDLE
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t            state;
  state_t            state_next;
  add_sel_t          sel;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  logic              sgn_q;
  logic              neg;
  logic              cy;

  logic [WIDTH-1:0]  add_a;
  logic [WIDTH-1:0]  add_b;
  logic              add_cin;
  logic [WIDTH-1:0]  add_sum;
  logic              add_cout;
  logic [WIDTH-1:0]  acc_hi;
  logic              acc_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and adder operand selection.
  always_comb begin
    state_next = state;
    sel        = SEL_ACC;
    case (state)
      ST_IDLE:   if (start_valid && start_ready) state_next = ST_ABS_A;
      ST_ABS_A:  begin sel = SEL_INV_MCAND; state_next = ST_ABS_B; end
      ST_ABS_B:  begin sel = SEL_INV_LO;    state_next = ST_MUL;   end
      ST_MUL: begin
        sel = SEL_ACC;
        if (cnt == CNT_W'(WIDTH - 1)) state_next = ST_NEG_LO;
      end
      ST_NEG_LO: begin sel = SEL_INV_LO; state_next = ST_NEG_HI; end
      ST_NEG_HI: begin sel = SEL_INV_HI; state_next = ST_DONE;   end
      // First DONE cycle publishes P; the handshake is taken from then on.
      ST_DONE:   if (res_valid && res_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Shared adder operand mux.
  always_comb begin
    add_a   = hi;
    add_b   = mcand;
    add_cin = 1'b0;
    case (sel)
      SEL_INV_MCAND: begin add_a = ~mcand; add_b = '0; add_cin = 1'b1; end
      SEL_INV_LO:    begin add_a = ~lo;    add_b = '0; add_cin = 1'b1; end
      SEL_INV_HI:    begin add_a = ~hi;    add_b = '0; add_cin = cy;   end
      default:       ;
    endcase
  end

  add32 #(.WIDTH(WIDTH)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Partial-product accumulate: add mcand only when the multiplier LSB is set.
  assign acc_hi = lo[0] ? add_sum : hi;
  assign acc_c  = lo[0] & add_cout;

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_ready <= 1'b1;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      P           <= '0;
      cnt         <= '0;
      mcand       <= '0;
      hi          <= '0;
      lo          <= '0;
      sgn_q       <= 1'b0;
      neg         <= 1'b0;
      cy          <= 1'b0;
    end else begin
      start_ready <= (state_next == ST_IDLE);
      busy        <= (state_next != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (start_valid && start_ready) begin
            mcand <= A;
            lo    <= B;
            hi    <= '0;
            sgn_q <= sgn;
            neg   <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
            cnt   <= '0;
            cy    <= 1'b0;
          end
        end
        ST_ABS_A: if (sgn_q && mcand[WIDTH-1]) mcand <= add_sum;
        ST_ABS_B: if (sgn_q && lo[WIDTH-1])    lo    <= add_sum;
        ST_MUL: begin
          // {c,hi,lo} >> 1 after the conditional add.
          hi  <= {acc_c, acc_hi[WIDTH-1:1]};
          lo  <= {acc_hi[0], lo[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        ST_NEG_LO: begin
          if (neg) {cy, lo} <= {add_cout, add_sum};
          else     cy       <= 1'b0;
        end
        ST_NEG_HI: if (neg) hi <= add_sum;
        ST_DONE: begin
          if (!res_valid) begin
            res_valid <= 1'b1;
            P         <= {hi, lo};
          end else if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
